mv_avalon_fifo_loader: RTL and testbench



---
 rtl/mv_loader_pkg.sv | 26 ++
 rtl/mv_avalon_fifo_loader.sv | 127 ++++++++++++
 tb/tb_mv_avalon_fifo_loader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mv_loader_pkg.sv
// Shared types and constants for the matrix-vector FIFO loader: FSM state
// codes, matrix geometry and the word-address helper.
package mv_loader_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int BYTE_W = 8;
  localparam int WORD_W = COLS * BYTE_W;
  localparam int ADDR_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_REQ  = 4'd1,
    ST_WAIT = 4'd2,
    ST_PUSH = 4'd3,
    ST_DONE = 4'd4
  } state_t;

  // Row index ROWS selects the B vector word; lower indices select rows of A.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [3:0]        row,
                                                 input logic [ADDR_W-1:0] a_base,
                                                 input logic [ADDR_W-1:0] b_addr);
    return (row == 4'(ROWS)) ? b_addr : a_base + ADDR_W'(row);
  endfunction

endpackage

// File: rtl/mv_avalon_fifo_loader.sv
// Avalon-MM read master loading an 8x8 byte matrix A and 8-byte vector B into
// the compute engine FIFOs. Optional debug taps enabled by LOADER_DBG_EN.
module mv_avalon_fifo_loader
  import mv_loader_pkg::*;
#(
  parameter logic [31:0] A_BASE = 32'd0,
  parameter logic [31:0] B_ADDR = 32'd8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        avm_address,
  output logic               avm_read,
  input  logic [WORD_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  input  logic               avm_waitrequest,
  output logic [ROWS-1:0]    a_wren,
  output logic [WORD_W-1:0]  a_data_out,
  output logic               b_wren,
  output logic [BYTE_W-1:0]  b_data,
  input  logic [ROWS-1:0]    a_full,
  input  logic               b_full,
  output logic               done,
  output logic [3:0]         dbg_state,
  output logic [3:0]         dbg_row,
  output logic [3:0]         dbg_byte
);

  state_t            state;
  logic [3:0]        row;
  logic [3:0]        byte_idx;
  logic [WORD_W-1:0] word;
  logic              last_row;
  logic              target_full;

  assign last_row    = (row == 4'(ROWS));
  assign target_full = last_row ? b_full : a_full[row[2:0]];

  // NOTE: every register here, the word shift register included, takes <= so
  // all updates land together at the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row         <= '0;
      byte_idx    <= '0;
      word        <= '0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      a_wren      <= '0;
      a_data_out  <= '0;
      b_wren      <= 1'b0;
      b_data      <= '0;
      done        <= 1'b0;
    end else begin
      // NOTE: FIFO strobes default low each cycle, so a write is a single-cycle pulse.
      a_wren     <= '0;
      a_data_out <= '0;
      b_wren     <= 1'b0;
      b_data     <= '0;

      case (state)
        ST_IDLE: begin
          avm_read    <= 1'b1;
          avm_address <= row_addr(row, A_BASE, B_ADDR);
          state       <= ST_REQ;
        end

        ST_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (avm_readdatavalid) begin
            word     <= avm_readdata;
            byte_idx <= '0;
            state    <= ST_PUSH;
          end
        end

        ST_PUSH: begin
          // A full target stalls the push; the byte index and word stay put.
          if (!target_full) begin
            if (last_row) begin
              b_wren <= 1'b1;
              b_data <= word[WORD_W-1 -: BYTE_W];
            end else begin
              a_wren[row[2:0]]                      <= 1'b1;
              a_data_out[row[2:0]*BYTE_W +: BYTE_W] <= word[WORD_W-1 -: BYTE_W];
            end
            word <= word << BYTE_W;

            if (byte_idx == 4'(COLS-1)) begin
              byte_idx <= '0;
              row      <= row + 4'd1;
              if (last_row) begin
                state <= ST_DONE;
              end else begin
                avm_read    <= 1'b1;
                avm_address <= row_addr(row + 4'd1, A_BASE, B_ADDR);
                state       <= ST_REQ;
              end
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end

        ST_DONE: done <= 1'b1;

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_DBG_EN
  assign dbg_state = state;
  assign dbg_row   = row;
  assign dbg_byte  = byte_idx;
`else
  assign dbg_state = '0;
  assign dbg_row   = '0;
  assign dbg_byte  = '0;
`endif

endmodule

// File: tb/tb_mv_avalon_fifo_loader.sv
// Self-checking bench for mv_avalon_fifo_loader: memory slave model plus a
// scoreboard of expected FIFO pushes filled as read data is returned.
`timescale 1ns/1ps
module tb_mv_avalon_fifo_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [63:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [7:0]  a_wren;
  logic [63:0] a_data_out;
  logic        b_wren;
  logic [7:0]  b_data;
  logic [7:0]  a_full = '0;
  logic        b_full = 1'b0;
  logic        done;
  logic [3:0]  dbg_state, dbg_row, dbg_byte;

  mv_avalon_fifo_loader dut (
    .clk(clk), .rst_n(rst_n),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest),
    .a_wren(a_wren), .a_data_out(a_data_out),
    .b_wren(b_wren), .b_data(b_data),
    .a_full(a_full), .b_full(b_full), .done(done),
    .dbg_state(dbg_state), .dbg_row(dbg_row), .dbg_byte(dbg_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } push_t;

  int          errors = 0;
  int          checks = 0;
  push_t       exp_q[$];
  logic [63:0] mem[16];
  int          cycle = 0;
  int          lane_cnt[9];
  int          lane0_cyc[8];
  logic [7:0]  lane0_data[8];
  int          reads, read_hi_first, first_addr;
  int          last_a_cycle, first_b_cycle, last_b_cycle, done_cycle;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          stall_left, full_lane, full_left;
  bit          full_arm, full_fired, spurious, dbg_nonzero;
  logic        prev_read = 1'b0, prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic clear_tb_state();
    exp_q.delete();
    foreach (lane_cnt[i]) lane_cnt[i] = 0;
    reads = 0; read_hi_first = 0; first_addr = -1;
    last_a_cycle = -1; first_b_cycle = -1; last_b_cycle = -1; done_cycle = -1;
    stall_left = 0; full_lane = 0; full_left = 0;
    full_arm = 0; full_fired = 0; spurious = 0; dbg_nonzero = 0;
  endtask

  // Slave model and push monitor: everything happens on the falling edge.
  initial begin : bus_model
    int         lane;
    logic [7:0] d;
    logic [63:0] other;
    push_t      e;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        a_full = '0; b_full = 1'b0; pend_cnt = 0; full_left = 0;
        prev_read = 1'b0; prev_wait = 1'b0;
      end else begin
        if (a_wren != '0 || b_wren) begin
          lane = -1; d = '0; other = a_data_out;
          if (b_wren && a_wren == '0) begin
            lane = 8; d = b_data;
          end else if (!b_wren && $onehot(a_wren)) begin
            for (int i = 0; i < 8; i++) if (a_wren[i]) lane = i;
            d = a_data_out[lane*8 +: 8];
            other = a_data_out & ~(64'hFF << (lane*8));
          end
          checks++;
          if (lane < 0 || other != '0) begin
            errors++;
            $display("FAIL push_shape: a_wren=%h b_wren=%b a_data_out=%h, required one target and idle lanes 0",
                     a_wren, b_wren, a_data_out);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_push: lane %0d data %h, required no push", lane, d);
          end else begin
            e = exp_q.pop_front();
            if (e.lane != lane || e.data !== d) begin
              errors++;
              $display("FAIL push_data: lane %0d data %h, required lane %0d data %h", lane, d, e.lane, e.data);
            end
          end
          if (lane >= 0) begin
            if (lane == 0 && lane_cnt[0] < 8) begin
              lane0_cyc[lane_cnt[0]]  = cycle;
              lane0_data[lane_cnt[0]] = d;
            end
            lane_cnt[lane]++;
            if (lane < 8) last_a_cycle = cycle;
            else begin
              if (lane_cnt[8] == 1) first_b_cycle = cycle;
              last_b_cycle = cycle;
            end
          end
        end

        if (full_left > 0) begin
          checks++;
          if (a_wren[full_lane] !== 1'b0) begin
            errors++;
            $display("FAIL full_block: a_wren=%h while lane %0d full, required bit low", a_wren, full_lane);
          end
`ifdef LOADER_DBG_EN
          checks++;
          if (dbg_byte !== 4'd3) begin
            errors++;
            $display("FAIL full_dbg_byte: dbg_byte=%0d, required 3", dbg_byte);
          end
`endif
          full_left--;
          if (full_left == 0) a_full[full_lane] = 1'b0;
        end

        if (done && done_cycle < 0) done_cycle = cycle;
`ifndef LOADER_DBG_EN
        if ((dbg_state | dbg_row | dbg_byte) != 4'd0) dbg_nonzero = 1;
`endif

        if (avm_read && prev_read && prev_wait) begin
          checks++;
          if (avm_address !== prev_addr) begin
            errors++;
            $display("FAIL req_hold: address %h during stall, required %h", avm_address, prev_addr);
          end
        end
        if (avm_read && !prev_read) begin
          checks++;
          if (pend_cnt != 0) begin
            errors++;
            $display("FAIL outstanding: new read with %0d pending, required 0", pend_cnt);
          end
        end

        avm_readdatavalid = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem[pend_addr[3:0]];
            for (int k = 0; k < 8; k++) begin
              e.lane = int'(pend_addr);
              e.data = avm_readdata[63-8*k -: 8];
              exp_q.push_back(e);
            end
          end
        end else if (spurious) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = 64'hDEAD_BEEF_0BAD_F00D;
          spurious = 0;
        end

        prev_read = avm_read;
        prev_addr = avm_address;
        avm_waitrequest = 1'b0;
        if (avm_read) begin
          if (reads == 0) read_hi_first++;
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            if (reads == 0) first_addr = int'(avm_address);
            reads++;
            pend_addr = avm_address;
            pend_cnt = 3;
          end
        end
        prev_wait = avm_waitrequest;

        if (full_arm && !full_fired && lane_cnt[full_lane] == 3) begin
          a_full[full_lane] = 1'b1;
          full_left = 5;
          full_fired = 1;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    clear_tb_state();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_to_done(input string name);
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_dbg;
    repeat (3) @(negedge clk); #1;
    checks++;
    if ({avm_read, avm_address, a_wren, a_data_out, b_wren, b_data, done,
         dbg_state, dbg_row, dbg_byte} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: read=%b addr=%h a_wren=%h b_wren=%b done=%b dbg=%h/%h/%h, required all 0",
               avm_read, avm_address, a_wren, b_wren, done, dbg_state, dbg_row, dbg_byte);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
`ifdef LOADER_DBG_EN
    exp_dbg = 4'd1;
`else
    exp_dbg = 4'd0;
`endif
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'd0 || dbg_state !== exp_dbg) begin
      errors++;
      $display("FAIL first_req: read=%b addr=%h dbg_state=%0d, required 1/0/%0d",
               avm_read, avm_address, dbg_state, exp_dbg);
    end
  endtask

  task automatic test_first_row();
    apply_reset();
    run_to_done("first_row");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lane0_data[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL row0_byte%0d: %h, required %h", i, lane0_data[i], 8'(i + 1));
      end
    end
    checks++;
    if (lane0_cyc[7] - lane0_cyc[0] != 7) begin
      errors++;
      $display("FAIL row0_back_to_back: span %0d cycles, required 7", lane0_cyc[7] - lane0_cyc[0]);
    end
  endtask

  task automatic test_waitrequest();
    apply_reset();
    stall_left = 3;
    run_to_done("waitrequest");
    checks++;
    if (read_hi_first != 4 || first_addr != 0) begin
      errors++;
      $display("FAIL stall_read: read high %0d cycles addr %0d, required 4 cycles addr 0", read_hi_first, first_addr);
    end
    checks++;
    if (reads != 9) begin
      errors++;
      $display("FAIL read_count: %0d reads, required 9", reads);
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    full_lane = 2;
    full_arm  = 1;
    run_to_done("full_stall");
    checks++;
    if (!full_fired || lane_cnt[2] != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_resume: fired=%0d lane2=%0d pending=%0d, required 1/8/0",
               full_fired, lane_cnt[2], exp_q.size());
    end
  endtask

  task automatic test_full_run();
    int total;
    apply_reset();
    run_to_done("full_run");
    for (int l = 0; l < 9; l++) begin
      checks++;
      if (lane_cnt[l] != 8) begin
        errors++;
        $display("FAIL lane%0d_count: %0d pushes, required 8", l, lane_cnt[l]);
      end
    end
    checks++;
    if (first_b_cycle <= last_a_cycle) begin
      errors++;
      $display("FAIL b_after_a: first B cycle %0d, last A cycle %0d, required later", first_b_cycle, last_a_cycle);
    end
    checks++;
    if (done_cycle != last_b_cycle + 1) begin
      errors++;
      $display("FAIL done_timing: done at %0d, required %0d", done_cycle, last_b_cycle + 1);
    end
    total = 0;
    spurious = 1;
    repeat (20) begin
      @(negedge clk); #1;
      if (!done || avm_read || a_wren != '0 || b_wren) total++;
    end
    checks++;
    if (total != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_sticky: %0d active cycles after done, %0d pending, required 0/0", total, exp_q.size());
    end
`ifdef LOADER_DBG_EN
    checks++;
    if (dbg_state !== 4'd4 || dbg_row !== 4'd9) begin
      errors++;
      $display("FAIL dbg_done: state %0d row %0d, required 4/9", dbg_state, dbg_row);
    end
`else
    checks++;
    if (dbg_nonzero) begin
      errors++;
      $display("FAIL dbg_tied: dbg outputs moved, required 0");
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    while (lane_cnt[4] < 2 && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (lane_cnt[4] < 2) begin
      errors++;
      $display("FAIL mid_reach_row4: lane4 pushes %0d, required 2", lane_cnt[4]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_address, a_wren, a_data_out, b_wren, b_data, done} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: read=%b addr=%h a_wren=%h data=%h done=%b, required all 0",
               avm_read, avm_address, a_wren, a_data_out, done);
    end
    clear_tb_state();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_to_done("mid_reset");
    checks++;
    if (first_addr != 0 || lane_cnt[0] != 8 || lane_cnt[8] != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_restart: first addr %0d lane0 %0d B %0d pending %0d, required 0/8/8/0",
               first_addr, lane_cnt[0], lane_cnt[8], exp_q.size());
    end
  endtask

  initial begin
    mem[0] = 64'h0102_0304_0506_0708;
    for (int r = 1; r < 16; r++) begin
      mem[r] = '0;
      for (int k = 0; k < 8; k++) mem[r][63-8*k -: 8] = 8'((r << 4) | k);
    end
    mem[8] = 64'hB0B1_B2B3_B4B5_B6B7;
    clear_tb_state();

    test_reset();
    test_first_row();
    test_waitrequest();
    test_full_stall();
    test_full_run();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
